sync_up_down_counter_nbit: RTL



---
 rtl/sync_up_down_counter_nbit.sv | 74 +++++++
 1 files changed

// File: rtl/sync_up_down_counter_nbit.sv
// ============================================================================
// Module      : sync_up_down_counter_nbit
// Description : Synchronous n-bit up/down counter with enable, parallel load
//               and combinational terminal count. Define COUNTER_MOD_EN to
//               count modulo MOD instead of 2**n.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_up_down_counter_nbit #(
    parameter int n   = 3,
    parameter int MOD = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         sel,
    input  logic         load,
    input  logic [n-1:0] d,
    output logic [n-1:0] Q,
    output logic         tc
);

`ifdef COUNTER_MOD_EN
    localparam logic [n-1:0] c_MAX = n'(MOD - 1);
`else
    // Full binary range; MOD only matters in the modulo build.
    localparam logic [n-1:0] c_MAX = (MOD > 0) ? {n{1'b1}} : {n{1'b1}};
`endif

    logic [n-1:0] r_q;
    logic [n-1:0] w_next;
    logic [n-1:0] w_load_val;
    logic         w_at_max;
    logic         w_at_zero;

`ifdef COUNTER_MOD_EN
    assign w_load_val = (d > c_MAX) ? c_MAX : d;
    // Treat any out-of-range value as the top so counting up recovers to 0.
    assign w_at_max   = (r_q >= c_MAX);
`else
    assign w_load_val = d;
    assign w_at_max   = (r_q == c_MAX);
`endif

    assign w_at_zero = (r_q == '0);

    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = w_load_val;
        end else if (en) begin
            if (sel) begin
                w_next = w_at_max ? '0 : r_q + 1'b1;
            end else begin
                w_next = w_at_zero ? c_MAX : r_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign Q  = r_q;
    assign tc = en & ((sel & (r_q == c_MAX)) | (~sel & w_at_zero));

endmodule

`default_nettype wire
